mseq: RTL and testbench

Sequential unsigned shift-add multiplier with its own control FSM. It sits beside the program counter as the coprocessor that a multiply instruction launches. Its `crdy` output drives the program counter's wait-opcode stall, so software issues a start, then waits, then reads `mres`. One partial-product step executes per clock, trading latency for a single W-bit adder.

---
 rtl/mseq.sv | 78 +++++++
 tb/tb_mseq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mseq.sv
// mseq: sequential unsigned shift-add multiplier with IDLE/BUSY control FSM
// Ports: ck clock; rb async active-low reset; mstr start request; mclr sync abort;
//        mopa/mopb W-bit unsigned operands; crdy ready (registered); mbsy busy (~crdy);
//        mres 2W-bit product of last completed operation; mcol sticky start-while-busy flag.
`timescale 1ns/1ps
module mseq #(
    parameter int W = 16
) (
    input  logic           ck,
    input  logic           rb,
    input  logic           mstr,
    input  logic           mclr,
    input  logic [W-1:0]   mopa,
    input  logic [W-1:0]   mopb,
    output logic           crdy,
    output logic           mbsy,
    output logic [2*W-1:0] mres,
    output logic           mcol
);
    localparam int CW = $clog2(W + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, nxt;
    logic [W-1:0]   ra;
    logic [2*W:0]   rp;
    logic [CW-1:0]  cnt;
    logic [W:0]     sum;
    logic [2*W:0]   step;
    logic           last;
    // One partial-product step: add multiplicand when the multiplier LSB is set,
    // then shift the whole accumulator/multiplier pair right with the carry.
    always_comb begin
        sum  = rp[0] ? {1'b0, rp[2*W-1:W]} + {1'b0, ra} : {1'b0, rp[2*W-1:W]};
        step = {1'b0, sum, rp[W-1:1]};
        last = cnt == CW'(1);
    end
    always_ff @(posedge ck or negedge rb)
        if (!rb) state <= IDLE;
        else     state <= nxt;
    always_comb
        nxt = (state == IDLE) ? ((mstr && !mclr) ? BUSY : IDLE)
                              : ((mclr || last) ? IDLE : BUSY);
    // Ready/busy are registered from the next state so they never glitch and
    // a start sampled at an edge already shows crdy=0 right after it.
    always_ff @(posedge ck or negedge rb)
        if (!rb) begin
            crdy <= 1'b1;
            mbsy <= 1'b0;
            mres <= '0;
            mcol <= 1'b0;
            ra   <= '0;
            rp   <= '0;
            cnt  <= '0;
        end else begin
            crdy <= nxt == IDLE;
            mbsy <= nxt == BUSY;
            if (state == IDLE) begin
                if (mclr) begin
                    mres <= '0;
                    mcol <= 1'b0;
                end else if (mstr) begin
                    ra   <= mopa;
                    rp   <= {{(W+1){1'b0}}, mopb};
                    cnt  <= CW'(W);
                    mcol <= 1'b0;
                end
            end else if (mclr) begin
                mres <= '0;
                ra   <= '0;
                rp   <= '0;
                cnt  <= '0;
            end else begin
                rp  <= step;
                cnt <= cnt - CW'(1);
                if (last) mres <= step[2*W-1:0];
                if (mstr) mcol <= 1'b1;
            end
        end
endmodule

// File: tb/tb_mseq.sv
// tb_mseq: scoreboard-driven self-checking bench for the mseq multiplier
`timescale 1ns/1ps
module tb_mseq;
    localparam int W = 16;
    logic           ck = 1'b0;
    logic           rb = 1'b1;
    logic           mstr = 1'b0;
    logic           mclr = 1'b0;
    logic [W-1:0]   mopa = '0;
    logic [W-1:0]   mopb = '0;
    logic           crdy, mbsy, mcol;
    logic [2*W-1:0] mres;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] e;
    int             total = 0;
    int             bad = 0;

    always #5 ck = ~ck;

    mseq #(.W(W)) dut (
        .ck(ck), .rb(rb), .mstr(mstr), .mclr(mclr), .mopa(mopa), .mopb(mopb),
        .crdy(crdy), .mbsy(mbsy), .mres(mres), .mcol(mcol)
    );

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        mopa = a;
        mopb = b;
        mstr = 1'b1;
        if (push) exp_q.push_back(32'(a) * 32'(b));
        tick();
        mstr = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!crdy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        #2 rb = 1'b0;
        #1;
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL reset_crdy got=%b want=1", crdy); end
        total++; if (mbsy !== 1'b0) begin bad++; $display("FAIL reset_mbsy got=%b want=0", mbsy); end
        total++; if (mres !== '0) begin bad++; $display("FAIL reset_mres got=%h want=0", mres); end
        total++; if (mcol !== 1'b0) begin bad++; $display("FAIL reset_mcol got=%b want=0", mcol); end
        tick();
        tick();
        rb = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int n;
        start(16'd3, 16'd5, 1'b1);
        total++; if (crdy !== 1'b0) begin bad++; $display("FAIL basic_crdy_low got=%b want=0", crdy); end
        total++; if (mbsy !== 1'b1) begin bad++; $display("FAIL basic_mbsy_high got=%b want=1", mbsy); end
        total++; if (mres !== '0) begin bad++; $display("FAIL basic_mres_hidden got=%h want=0", mres); end
        wait_done(n);
        e = exp_q.pop_front();
        total++; if (n !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", n); end
        total++; if (mres !== e) begin bad++; $display("FAIL basic_mres got=%h want=%h", mres, e); end
        total++; if (mbsy !== 1'b0) begin bad++; $display("FAIL basic_mbsy_low got=%b want=0", mbsy); end
    endtask

    task automatic test_max;
        int n;
        start(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(n);
        e = exp_q.pop_front();
        total++; if (n !== 16) begin bad++; $display("FAIL max_latency got=%0d want=16", n); end
        total++; if (mres !== e) begin bad++; $display("FAIL max_mres got=%h want=%h", mres, e); end
        start(16'h0000, 16'hFFFF, 1'b1);
        wait_done(n);
        e = exp_q.pop_front();
        total++; if (n !== 16) begin bad++; $display("FAIL zero_latency got=%0d want=16", n); end
        total++; if (mres !== e) begin bad++; $display("FAIL zero_mres got=%h want=%h", mres, e); end
    endtask

    task automatic test_collision;
        start(16'h1234, 16'h0010, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            mstr = (i == 6 || i == 16);
            mopa = 16'($urandom);
            mopb = 16'($urandom);
            tick();
            if (i == 6) begin
                total++; if (mcol !== 1'b1) begin bad++; $display("FAIL col_set got=%b want=1", mcol); end
            end
            if (i == 15) begin
                total++; if (crdy !== 1'b0) begin bad++; $display("FAIL col_still_busy got=%b want=0", crdy); end
            end
        end
        mstr = 1'b0;
        e = exp_q.pop_front();
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL col_done got=%b want=1", crdy); end
        total++; if (mres !== e) begin bad++; $display("FAIL col_mres got=%h want=%h", mres, e); end
        repeat (3) tick();
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL col_no_restart got=%b want=1", crdy); end
        total++; if (mcol !== 1'b1) begin bad++; $display("FAIL col_sticky got=%b want=1", mcol); end
    endtask

    task automatic test_abort;
        start(16'hABCD, 16'h1111, 1'b0);
        total++; if (mcol !== 1'b0) begin bad++; $display("FAIL abort_mcol_cleared got=%b want=0", mcol); end
        for (int i = 1; i <= 8; i++) begin
            mstr = (i == 3 || i == 8);
            mclr = (i == 8);
            tick();
        end
        mstr = 1'b0;
        mclr = 1'b0;
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL abort_crdy got=%b want=1", crdy); end
        total++; if (mbsy !== 1'b0) begin bad++; $display("FAIL abort_mbsy got=%b want=0", mbsy); end
        total++; if (mres !== '0) begin bad++; $display("FAIL abort_mres got=%h want=0", mres); end
        total++; if (mcol !== 1'b1) begin bad++; $display("FAIL abort_mcol got=%b want=1", mcol); end
        repeat (3) tick();
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL abort_no_start got=%b want=1", crdy); end
        mclr = 1'b1;
        tick();
        mclr = 1'b0;
        total++; if (mcol !== 1'b0) begin bad++; $display("FAIL idle_clr_mcol got=%b want=0", mcol); end
    endtask

    task automatic test_async;
        int n;
        start(16'd11, 16'd13, 1'b1);
        wait_done(n);
        e = exp_q.pop_front();
        total++; if (mres !== e) begin bad++; $display("FAIL async_pre_mres got=%h want=%h", mres, e); end
        start(16'h0100, 16'h0200, 1'b0);
        repeat (5) tick();
        #2 rb = 1'b0;
        #1;
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL async_crdy got=%b want=1", crdy); end
        total++; if (mbsy !== 1'b0) begin bad++; $display("FAIL async_mbsy got=%b want=0", mbsy); end
        total++; if (mres !== '0) begin bad++; $display("FAIL async_mres got=%h want=0", mres); end
        @(negedge ck);
        rb = 1'b1;
        tick();
        total++; if (crdy !== 1'b1) begin bad++; $display("FAIL async_idle got=%b want=1", crdy); end
        start(16'd7, 16'd9, 1'b1);
        wait_done(n);
        e = exp_q.pop_front();
        total++; if (n !== 16) begin bad++; $display("FAIL async_post_latency got=%0d want=16", n); end
        total++; if (mres !== e) begin bad++; $display("FAIL async_post_mres got=%h want=%h", mres, e); end
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        start(16'h00FF, 16'h0101, 1'b1);
        wait_done(n1);
        e = exp_q.pop_front();
        total++; if (mres !== e) begin bad++; $display("FAIL b2b_first got=%h want=%h", mres, e); end
        start(16'hBEEF, 16'h0003, 1'b1);
        total++; if (crdy !== 1'b0) begin bad++; $display("FAIL b2b_accepted got=%b want=0", crdy); end
        wait_done(n2);
        e = exp_q.pop_front();
        total++; if (n2 + 1 !== 17) begin bad++; $display("FAIL b2b_spacing got=%0d want=17", n2 + 1); end
        total++; if (mres !== e) begin bad++; $display("FAIL b2b_second got=%h want=%h", mres, e); end
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 500; k++) begin
            start(16'($urandom), 16'($urandom), 1'b1);
            wait_done(n);
            e = exp_q.pop_front();
            total++; if (n !== 16) begin bad++; $display("FAIL rand_latency idx=%0d got=%0d want=16", k, n); end
            total++; if (mres !== e) begin bad++; $display("FAIL rand_mres idx=%0d got=%h want=%h", k, mres, e); end
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_collision();
        test_abort();
        test_async();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
